// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction classes and the opcode -> class/static-select decoder.
package uc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  // Classes capture only what the sequencer needs; datapath differences
  // inside a class live in the static selects.
  typedef enum logic [3:0] {
    CL_ALU, CL_MULDIV, CL_LOWO, CL_STWO, CL_JMP, CL_OUT,
    CL_IN, CL_JAL, CL_SCAN, CL_NOP, CL_HLT, CL_ILL
  } class_t;

  typedef struct packed {
    logic       onop;
    logic       mux_end;
    logic       select_d;
    logic       end_pc_or_reg;
    logic [1:0] ctrl_m5;
    logic [1:0] select_dado;
    logic [2:0] select_size;
  } sel_t;

  typedef struct packed {
    class_t cls;
    sel_t   sel;
  } dec_t;

  localparam logic [5:0] OP_ADC  = 6'h00, OP_ADCI  = 6'h01, OP_SUB   = 6'h02, OP_SUBI  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h04, OP_OR    = 6'h05, OP_NOT   = 6'h06, OP_LOWO  = 6'h07;
  localparam logic [5:0] OP_STWO = 6'h08, OP_LOI   = 6'h09, OP_MOV   = 6'h0A, OP_SLEL  = 6'h0B;
  localparam logic [5:0] OP_SRIL = 6'h0C, OP_SLET  = 6'h0D, OP_SGRT  = 6'h0E, OP_XOR   = 6'h0F;
  localparam logic [5:0] OP_NAND = 6'h10, OP_NOR   = 6'h11, OP_JUMP  = 6'h12, OP_JMPR  = 6'h13;
  localparam logic [5:0] OP_IN   = 6'h14, OP_OUT   = 6'h15, OP_NOP   = 6'h16, OP_HLT   = 6'h17;
  localparam logic [5:0] OP_BEQ  = 6'h18, OP_BNEQ  = 6'h19, OP_BLZ   = 6'h1A, OP_MULT  = 6'h1B;
  localparam logic [5:0] OP_MULTI= 6'h1C, OP_DIV   = 6'h1D, OP_DIVI  = 6'h1E, OP_MOD   = 6'h1F;
  localparam logic [5:0] OP_MODI = 6'h20, OP_SLETI = 6'h21, OP_SGRTI = 6'h22, OP_ANDI  = 6'h23;
  localparam logic [5:0] OP_ORI  = 6'h24, OP_JAL   = 6'h25, OP_BLT   = 6'h26, OP_BGRT  = 6'h27;
  localparam logic [5:0] OP_BEQI = 6'h28, OP_BNEQI = 6'h29, OP_BLTI  = 6'h2A, OP_BGRTI = 6'h2B;
  localparam logic [5:0] OP_SCAN = 6'h2C;

  // Unlisted selects stay 0 and mux_end defaults to 1.
  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d.cls = CL_ILL;
    d.sel = '0;
    d.sel.mux_end = 1'b1;
    case (op)
      OP_ADC, OP_SUB, OP_AND, OP_OR, OP_SLET, OP_SGRT, OP_XOR, OP_NAND, OP_NOR,
      OP_MULT, OP_DIV, OP_MOD: begin
        d.cls = (op == OP_MULT || op == OP_DIV || op == OP_MOD) ? CL_MULDIV : CL_ALU;
        d.sel.ctrl_m5 = 2'b10;
        d.sel.onop    = 1'b1;
      end
      OP_ADCI, OP_SUBI, OP_SLEL, OP_SRIL, OP_SLETI, OP_SGRTI, OP_ANDI, OP_ORI,
      OP_MULTI, OP_DIVI, OP_MODI: begin
        d.cls = (op == OP_MULTI || op == OP_DIVI || op == OP_MODI) ? CL_MULDIV : CL_ALU;
        d.sel.ctrl_m5  = 2'b01;
        d.sel.select_d = 1'b1;
        d.sel.onop     = 1'b1;
        if (op == OP_DIVI || op == OP_MODI) d.sel.select_size = 3'b001;
      end
      OP_NOT: begin
        d.cls = CL_ALU;
        d.sel.ctrl_m5 = 2'b01;
        d.sel.onop    = 1'b1;
      end
      OP_LOWO: begin
        d.cls = CL_LOWO;
        d.sel.ctrl_m5     = 2'b01;
        d.sel.select_dado = 2'b10;
        d.sel.select_d    = 1'b1;
        d.sel.onop        = 1'b1;
      end
      OP_STWO: begin
        d.cls = CL_STWO;
        d.sel.select_d = 1'b1;
        d.sel.onop     = 1'b1;
      end
      OP_LOI: begin
        d.cls = CL_ALU;
        d.sel.select_size = 3'b001;
        d.sel.select_dado = 2'b11;
      end
      OP_MOV: begin
        d.cls = CL_ALU;
        d.sel.ctrl_m5     = 2'b01;
        d.sel.select_dado = 2'b01;
      end
      OP_IN: begin
        d.cls = CL_IN;
        d.sel.select_size = 3'b011;
        d.sel.select_dado = 2'b11;
        d.sel.select_d    = 1'b1;
      end
      OP_JAL: begin
        d.cls = CL_JAL;
        d.sel.select_size = 3'b010;
        d.sel.select_dado = 2'b11;
        d.sel.mux_end     = 1'b0;
      end
      OP_BEQ, OP_BNEQ, OP_BLZ, OP_BLT, OP_BGRT: begin
        d.cls = CL_JMP;
        d.sel.onop    = 1'b1;
        d.sel.mux_end = 1'b0;
      end
      OP_BEQI, OP_BNEQI, OP_BLTI, OP_BGRTI: begin
        d.cls = CL_JMP;
        d.sel.onop        = 1'b1;
        d.sel.mux_end     = 1'b0;
        d.sel.select_size = 3'b100;
        d.sel.select_d    = 1'b1;
      end
      OP_JUMP: begin
        d.cls = CL_JMP;
        d.sel.mux_end = 1'b0;
      end
      OP_JMPR: begin
        d.cls = CL_JMP;
        d.sel.mux_end       = 1'b0;
        d.sel.end_pc_or_reg = 1'b1;
      end
      OP_OUT:  d.cls = CL_OUT;
      OP_NOP:  d.cls = CL_NOP;
      OP_HLT:  d.cls = CL_HLT;
      OP_SCAN: d.cls = CL_SCAN;
      default: d.cls = CL_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uc_wait_counter.sv
// Loadable down-counter that times multi-cycle states; saturates at zero.
module uc_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on state entry, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Count register; reset comes in as a forced load from the parent.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes and selects.
//
//   state      | meaning
//   FETCH      | wait IMEM_LAT cycles, load IR on the last
//   DECODE     | classify opcode, latch static selects
//   EXEC       | ALU / branch / out; MULDIV_LAT cycles for mult/div/mod
//   MEM        | DMEM_LAT cycles for lowo/stwo
//   WB         | register write (flag write for scan)
//   WAIT_IN    | hold until inValid, then ack
//   HALT       | sticky until reset
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int IMEM_LAT   = 1,
  parameter int DMEM_LAT   = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                inValid,
  output logic                inAck,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                onWriteReg,
  output logic                writeDataMem,
  output logic                outputEnable,
  output logic                flagw,
  output logic                onskip,
  output logic                notOUT,
  output logic                onop,
  output logic                muxEnd,
  output logic                selectD,
  output logic                endPCorReg,
  output logic [1:0]          ctrlM5,
  output logic [1:0]          selectDado,
  output logic [2:0]          selectSize,
  output logic                HLT,
  output logic                illegal,
  output logic [2:0]          state
);

  localparam int MAX_ID  = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int MAX_LAT = (MAX_ID > MULDIV_LAT) ? MAX_ID : MULDIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  state_t         state_q, state_d;
  class_t         class_q;
  sel_t           sel_q;
  dec_t           dec;
  logic           cnt_load;
  logic [CW-1:0]  cnt_val;
  logic           cnt_done;

  assign dec = decode_op(6'(opcode));

  uc_wait_counter #(.W(CW)) u_wait (
    .clk_i      (clock),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  // State register plus per-instruction class/select latch taken in DECODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      class_q <= CL_NOP;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        class_q <= dec.cls;
        sel_q   <= dec.sel;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (cnt_done) state_d = ST_DECODE;
      ST_DECODE: begin
        case (dec.cls)
          CL_HLT:         state_d = ST_HALT;
          CL_IN:          state_d = ST_WAIT_IN;
          CL_NOP, CL_ILL: state_d = ST_FETCH;
          default:        state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (cnt_done) begin
          case (class_q)
            CL_JMP, CL_OUT:   state_d = ST_FETCH;
            CL_LOWO, CL_STWO: state_d = ST_MEM;
            default:          state_d = ST_WB;
          endcase
        end
      end
      ST_MEM:     if (cnt_done) state_d = (class_q == CL_STWO) ? ST_FETCH : ST_WB;
      ST_WB:      state_d = ST_FETCH;
      ST_WAIT_IN: if (inValid) state_d = ST_WB;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Wait-counter reload on every state entry; reset counts as entering FETCH.
  always_comb begin
    cnt_load = reset || (state_d != state_q);
    cnt_val  = '0;
    if (reset) begin
      cnt_val = CW'(IMEM_LAT - 1);
    end else begin
      case (state_d)
        ST_FETCH: cnt_val = CW'(IMEM_LAT - 1);
        ST_MEM:   cnt_val = CW'(DMEM_LAT - 1);
        ST_EXEC:  if (dec.cls == CL_MULDIV) cnt_val = CW'(MULDIV_LAT - 1);
        default:  cnt_val = '0;
      endcase
    end
  end

  // Phase-gated strobes; a cycle with reset high fires nothing.
  always_comb begin
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    onWriteReg   = 1'b0;
    writeDataMem = 1'b0;
    outputEnable = 1'b0;
    flagw        = 1'b0;
    onskip       = 1'b0;
    notOUT       = 1'b1;
    inAck        = 1'b0;
    HLT          = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH:  irWrite = cnt_done;
        ST_DECODE: begin
          pcWrite = (dec.cls == CL_NOP) || (dec.cls == CL_ILL);
          illegal = (dec.cls == CL_ILL);
        end
        ST_EXEC: begin
          if (cnt_done && class_q == CL_JMP) begin
            onskip  = 1'b1;
            pcWrite = 1'b1;
          end
          if (cnt_done && class_q == CL_OUT) begin
            outputEnable = 1'b1;
            notOUT       = 1'b0;
            pcWrite      = 1'b1;
          end
        end
        ST_MEM: begin
          if (cnt_done && class_q == CL_STWO) begin
            writeDataMem = 1'b1;
            pcWrite      = 1'b1;
          end
        end
        ST_WB: begin
          pcWrite    = 1'b1;
          flagw      = (class_q == CL_SCAN);
          onWriteReg = (class_q != CL_SCAN);
          onskip     = (class_q == CL_JAL);
        end
        ST_WAIT_IN: inAck = inValid;
        ST_HALT:    HLT = 1'b1;
        default:    ;
      endcase
    end
  end

  assign onop       = sel_q.onop;
  assign muxEnd     = sel_q.mux_end;
  assign selectD    = sel_q.select_d;
  assign endPCorReg = sel_q.end_pc_or_reg;
  assign ctrlM5     = sel_q.ctrl_m5;
  assign selectDado = sel_q.select_dado;
  assign selectSize = sel_q.select_size;
  assign state      = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo (IMEM_LAT=1, DMEM_LAT=3, MULDIV_LAT=4).
module tb_uc_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       inValid;
  logic       inAck, irWrite, pcWrite, onWriteReg, writeDataMem, outputEnable;
  logic       flagw, onskip, notOUT, onop, muxEnd, selectD, endPCorReg, HLT, illegal;
  logic [1:0] ctrlM5, selectDado;
  logic [2:0] selectSize, state;

  int n_chk  = 0;
  int n_fail = 0;

  uc_multiciclo #(
    .OPCODE_W(6), .IMEM_LAT(1), .DMEM_LAT(3), .MULDIV_LAT(4)
  ) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .inValid(inValid),
    .inAck(inAck), .irWrite(irWrite), .pcWrite(pcWrite), .onWriteReg(onWriteReg),
    .writeDataMem(writeDataMem), .outputEnable(outputEnable), .flagw(flagw),
    .onskip(onskip), .notOUT(notOUT), .onop(onop), .muxEnd(muxEnd),
    .selectD(selectD), .endPCorReg(endPCorReg), .ctrlM5(ctrlM5),
    .selectDado(selectDado), .selectSize(selectSize), .HLT(HLT),
    .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  // Strobe bit positions in the observed vector below.
  localparam logic [10:0] IR = 11'h400, PC = 11'h200, WR = 11'h100, WDM = 11'h080;
  localparam logic [10:0] SK = 11'h040, OE = 11'h020, NO = 11'h010, FW = 11'h008;
  localparam logic [10:0] ACK = 11'h004, HL = 11'h002, IL = 11'h001;

  logic [13:0] obs_vec;
  logic [10:0] sel_vec;
  assign obs_vec = {state, irWrite, pcWrite, onWriteReg, writeDataMem, onskip,
                    outputEnable, notOUT, flagw, inAck, HLT, illegal};
  assign sel_vec = {onop, muxEnd, selectD, endPCorReg, ctrlM5, selectDado, selectSize};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs set; checks this cycle, moves to the next.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] fl);
    #1;
    check(tag, 32'(obs_vec), 32'({st, fl}));
    @(negedge clock);
  endtask

  function automatic logic [10:0] sv(input logic op, input logic me, input logic sd,
                                     input logic ep, input logic [1:0] c5,
                                     input logic [1:0] dd, input logic [2:0] sz);
    return {op, me, sd, ep, c5, dd, sz};
  endfunction

  initial begin
    reset = 1'b1; opcode = 6'h00; inValid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst.strobes", 32'(obs_vec), 32'({3'd0, NO}));
    check("rst.sels", 32'(sel_vec), 32'(0));
    reset = 1'b0;

    // adc
    opcode = 6'h00;
    cyc("adc.fetch", 3'd0, IR | NO);
    cyc("adc.decode", 3'd1, NO);
    cyc("adc.exec", 3'd2, NO);
    check("adc.sel", 32'(sel_vec), 32'(sv(1, 1, 0, 0, 2'b10, 2'b00, 3'b000)));
    cyc("adc.wb", 3'd4, PC | WR | NO);

    // div: 4-cycle EXEC
    opcode = 6'h1D;
    cyc("div.fetch", 3'd0, IR | NO);
    cyc("div.decode", 3'd1, NO);
    for (int i = 0; i < 4; i++) cyc("div.exec", 3'd2, NO);
    cyc("div.wb", 3'd4, PC | WR | NO);

    // in: inValid arrives 5 cycles into WAIT_IN
    opcode = 6'h14;
    cyc("in.fetch", 3'd0, IR | NO);
    cyc("in.decode", 3'd1, NO);
    for (int i = 0; i < 5; i++) cyc("in.wait", 3'd5, NO);
    inValid = 1'b1;
    cyc("in.ack", 3'd5, ACK | NO);
    inValid = 1'b0;
    check("in.sel", 32'(sel_vec), 32'(sv(0, 1, 1, 0, 2'b00, 2'b11, 3'b011)));
    cyc("in.wb", 3'd4, PC | WR | NO);

    // out, with a stray inValid that must be ignored
    opcode = 6'h15; inValid = 1'b1;
    cyc("out.fetch", 3'd0, IR | NO);
    cyc("out.decode", 3'd1, NO);
    cyc("out.exec", 3'd2, PC | OE);
    inValid = 1'b0;

    // stwo: 3-cycle MEM, store on the last
    opcode = 6'h08;
    cyc("stwo.fetch", 3'd0, IR | NO);
    cyc("stwo.decode", 3'd1, NO);
    cyc("stwo.exec", 3'd2, NO);
    cyc("stwo.mem1", 3'd3, NO);
    cyc("stwo.mem2", 3'd3, NO);
    cyc("stwo.mem3", 3'd3, WDM | PC | NO);

    // lowo: MEM then WB
    opcode = 6'h07;
    cyc("lowo.fetch", 3'd0, IR | NO);
    cyc("lowo.decode", 3'd1, NO);
    cyc("lowo.exec", 3'd2, NO);
    for (int i = 0; i < 3; i++) cyc("lowo.mem", 3'd3, NO);
    check("lowo.sel", 32'(sel_vec), 32'(sv(1, 1, 1, 0, 2'b01, 2'b10, 3'b000)));
    cyc("lowo.wb", 3'd4, PC | WR | NO);

    // scan: flag write instead of register write
    opcode = 6'h2C;
    cyc("scan.fetch", 3'd0, IR | NO);
    cyc("scan.decode", 3'd1, NO);
    cyc("scan.exec", 3'd2, NO);
    cyc("scan.wb", 3'd4, PC | FW | NO);

    // jal: register write plus skip
    opcode = 6'h25;
    cyc("jal.fetch", 3'd0, IR | NO);
    cyc("jal.decode", 3'd1, NO);
    cyc("jal.exec", 3'd2, NO);
    check("jal.sel", 32'(sel_vec), 32'(sv(0, 0, 0, 0, 2'b00, 2'b11, 3'b010)));
    cyc("jal.wb", 3'd4, PC | WR | SK | NO);

    // beqi
    opcode = 6'h28;
    cyc("beqi.fetch", 3'd0, IR | NO);
    cyc("beqi.decode", 3'd1, NO);
    cyc("beqi.exec", 3'd2, PC | SK | NO);
    check("beqi.sel", 32'(sel_vec), 32'(sv(1, 0, 1, 0, 2'b00, 2'b00, 3'b100)));

    // jmpr
    opcode = 6'h13;
    cyc("jmpr.fetch", 3'd0, IR | NO);
    cyc("jmpr.decode", 3'd1, NO);
    cyc("jmpr.exec", 3'd2, PC | SK | NO);
    check("jmpr.sel", 32'(sel_vec), 32'(sv(0, 0, 0, 1, 2'b00, 2'b00, 3'b000)));

    // nop
    opcode = 6'h16;
    cyc("nop.fetch", 3'd0, IR | NO);
    cyc("nop.decode", 3'd1, PC | NO);

    // unmapped opcode
    opcode = 6'h3F;
    cyc("ill.fetch", 3'd0, IR | NO);
    cyc("ill.decode", 3'd1, PC | IL | NO);

    // adc aborted by reset in WB
    opcode = 6'h00;
    cyc("abort.fetch", 3'd0, IR | NO);
    cyc("abort.decode", 3'd1, NO);
    cyc("abort.exec", 3'd2, NO);
    reset = 1'b1;
    cyc("abort.wb", 3'd4, NO);
    cyc("abort.rst", 3'd0, NO);
    reset = 1'b0;

    // hlt, sticky for 10 cycles, then reset
    opcode = 6'h17;
    cyc("hlt.fetch", 3'd0, IR | NO);
    cyc("hlt.decode", 3'd1, NO);
    for (int i = 0; i < 10; i++) begin
      inValid = i[0];
      cyc("hlt.halt", 3'd6, HL | NO);
    end
    inValid = 1'b0;
    reset = 1'b1;
    cyc("hlt.rstcyc", 3'd6, NO);
    cyc("hlt.after", 3'd0, NO);
    reset = 1'b0;

    opcode = 6'h16;
    cyc("post.fetch", 3'd0, IR | NO);
    cyc("post.decode", 3'd1, PC | NO);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
